// File: rtl/mesh_driver_pkg.sv
// Shared types for the mesh burst driver: op encoding, FSM states and the
// packet payload carried on the valid/ready link.
package mesh_driver_pkg;

    localparam int unsigned X_CORD_W = 2;
    localparam int unsigned Y_CORD_W = 2;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned LEN_W    = 8;
    localparam int unsigned MAX_OUT  = 4;

    localparam logic OP_STORE = 1'b0;
    localparam logic OP_LOAD  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic                op;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
        logic [X_CORD_W-1:0] dest_x;
        logic [Y_CORD_W-1:0] dest_y;
        logic [X_CORD_W-1:0] src_x;
        logic [Y_CORD_W-1:0] src_y;
    } pkt_s;

endpackage

// File: rtl/mesh_burst_driver_credit.sv
// Outstanding-request counter: saturating up/down with look-ahead flags so the
// driver can register decisions on the post-update value.
module mesh_credit_counter #(
    parameter int unsigned max_p = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic at_limit_c,
    output logic zero_c,
    output logic underflow_c
);

    localparam int unsigned CNT_W = $clog2(max_p + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_n;

    // Simultaneous inc and dec cancel; a dec at zero without inc is an underflow.
    always_comb begin
        count_n     = count_q;
        underflow_c = 1'b0;
        if (inc && !dec) begin
            if (count_q != CNT_W'(max_p)) begin
                count_n = count_q + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            if (count_q == '0) begin
                underflow_c = 1'b1;
            end else begin
                count_n = count_q - CNT_W'(1);
            end
        end
    end

    assign at_limit_c = (count_n == CNT_W'(max_p));
    assign zero_c     = (count_n == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_n;
        end
    end

endmodule

// File: rtl/mesh_burst_driver.sv
// Host-side burst driver: expands one command into per-word store/load packets,
// limits outstanding requests, returns load data and pulses finish when drained.
module mesh_burst_driver
    import mesh_driver_pkg::*;
#(
    parameter int unsigned x_cord_width_p = X_CORD_W,
    parameter int unsigned y_cord_width_p = Y_CORD_W,
    parameter int unsigned data_width_p   = DATA_W,
    parameter int unsigned addr_width_p   = ADDR_W,
    parameter int unsigned len_width_p    = LEN_W,
    parameter int unsigned max_out_p      = MAX_OUT
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [x_cord_width_p-1:0] my_x_i,
    input  logic [y_cord_width_p-1:0] my_y_i,
    input  logic                      cmd_v_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_op_i,
    input  logic [addr_width_p-1:0]   cmd_addr_i,
    input  logic [len_width_p-1:0]    cmd_len_i,
    input  logic [data_width_p-1:0]   cmd_data_i,
    input  logic [x_cord_width_p-1:0] cmd_dest_x_i,
    input  logic [y_cord_width_p-1:0] cmd_dest_y_i,
    output logic                      pkt_v_o,
    input  logic                      pkt_ready_i,
    output logic                      pkt_op_o,
    output logic [addr_width_p-1:0]   pkt_addr_o,
    output logic [data_width_p-1:0]   pkt_data_o,
    output logic [x_cord_width_p-1:0] pkt_dest_x_o,
    output logic [y_cord_width_p-1:0] pkt_dest_y_o,
    output logic [x_cord_width_p-1:0] pkt_src_x_o,
    output logic [y_cord_width_p-1:0] pkt_src_y_o,
    input  logic                      resp_v_i,
    input  logic [data_width_p-1:0]   resp_data_i,
    output logic                      rdata_v_o,
    output logic [data_width_p-1:0]   rdata_o,
    output logic                      busy_o,
    output logic                      finish_o,
    output logic                      error_o
);

    localparam int unsigned IDX_W = len_width_p;

    state_e                  state_q;
    state_e                  state_n;
    pkt_s                    pkt_q;
    logic [IDX_W-1:0]        len_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    cmd_ready_q;
    logic                    pkt_v_q;
    logic                    busy_q;
    logic                    finish_q;
    logic                    rdata_v_q;
    logic [data_width_p-1:0] rdata_q;
    logic                    error_q;

    logic accept;
    logic hs;
    logic last;
    logic at_limit_c;
    logic zero_c;
    logic underflow_c;

    assign accept = cmd_v_i && cmd_ready_q;
    assign hs     = pkt_v_q && pkt_ready_i;
    assign last   = (idx_q == (len_q - IDX_W'(1)));

    mesh_credit_counter #(
        .max_p (max_out_p)
    ) u_credit (
        .clk         (clk_i),
        .rst_n       (reset_n_i),
        .inc         (hs),
        .dec         (resp_v_i),
        .at_limit_c  (at_limit_c),
        .zero_c      (zero_c),
        .underflow_c (underflow_c)
    );

    // Next-state logic
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_n = (cmd_len_i == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (hs && last) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (zero_c) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // State, packet payload and registered outputs; decisions use next-state and
    // look-ahead credit so outputs line up with the state they describe.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            pkt_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            cmd_ready_q <= 1'b0;
            pkt_v_q     <= 1'b0;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
            rdata_v_q   <= 1'b0;
            rdata_q     <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_n;
            cmd_ready_q <= (state_n == ST_IDLE);
            busy_q      <= (state_n != ST_IDLE);
            finish_q    <= (state_q == ST_DONE);
            pkt_v_q     <= (state_n == ST_ISSUE) && !at_limit_c;
            rdata_v_q   <= resp_v_i && (pkt_q.op == OP_LOAD);
            error_q     <= error_q || underflow_c;
            if (resp_v_i) begin
                rdata_q <= resp_data_i;
            end
            if (accept) begin
                len_q        <= cmd_len_i;
                idx_q        <= '0;
                pkt_q.op     <= cmd_op_i;
                pkt_q.addr   <= cmd_addr_i;
                pkt_q.data   <= (cmd_op_i == OP_LOAD) ? '0 : cmd_data_i;
                pkt_q.dest_x <= cmd_dest_x_i;
                pkt_q.dest_y <= cmd_dest_y_i;
                pkt_q.src_x  <= my_x_i;
                pkt_q.src_y  <= my_y_i;
            end else if (hs) begin
                idx_q      <= idx_q + IDX_W'(1);
                pkt_q.addr <= pkt_q.addr + ADDR_W'(1);
                if (pkt_q.op == OP_STORE) begin
                    pkt_q.data <= pkt_q.data + DATA_W'(1);
                end
            end
        end
    end

    assign cmd_ready_o  = cmd_ready_q;
    assign pkt_v_o      = pkt_v_q;
    assign pkt_op_o     = pkt_q.op;
    assign pkt_addr_o   = pkt_q.addr;
    assign pkt_data_o   = pkt_q.data;
    assign pkt_dest_x_o = pkt_q.dest_x;
    assign pkt_dest_y_o = pkt_q.dest_y;
    assign pkt_src_x_o  = pkt_q.src_x;
    assign pkt_src_y_o  = pkt_q.src_y;
    assign rdata_v_o    = rdata_v_q;
    assign rdata_o      = rdata_q;
    assign busy_o       = busy_q;
    assign finish_o     = finish_q;
    assign error_o      = error_q;

endmodule

// File: tb/tb_mesh_burst_driver.sv
// Scoreboard bench for mesh_burst_driver: directed bursts push expected packets
// and load data; negedge monitors pop and compare, a responder models the mesh.
module tb_mesh_burst_driver;

    localparam int XW = 2;
    localparam int YW = 2;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int LW = 8;
    localparam int MO = 4;

    typedef struct packed {
        logic          op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [XW-1:0] dx;
        logic [YW-1:0] dy;
        logic [XW-1:0] sx;
        logic [YW-1:0] sy;
    } pkt_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [XW-1:0] my_x;
    logic [YW-1:0] my_y;
    logic          cmd_v;
    logic          cmd_ready;
    logic          cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] cmd_data;
    logic [XW-1:0] cmd_dx;
    logic [YW-1:0] cmd_dy;
    logic          pkt_v;
    logic          pkt_ready;
    logic          pkt_op;
    logic [AW-1:0] pkt_addr;
    logic [DW-1:0] pkt_data;
    logic [XW-1:0] pkt_dx;
    logic [YW-1:0] pkt_dy;
    logic [XW-1:0] pkt_sx;
    logic [YW-1:0] pkt_sy;
    logic          resp_v;
    logic [DW-1:0] resp_data;
    logic          rdata_v;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          finish;
    logic          error;

    mesh_burst_driver #(
        .x_cord_width_p (XW), .y_cord_width_p (YW), .data_width_p (DW),
        .addr_width_p   (AW), .len_width_p    (LW), .max_out_p    (MO)
    ) dut (
        .clk_i        (clk),       .reset_n_i    (rst_n),
        .my_x_i       (my_x),      .my_y_i       (my_y),
        .cmd_v_i      (cmd_v),     .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),    .cmd_addr_i   (cmd_addr),
        .cmd_len_i    (cmd_len),   .cmd_data_i   (cmd_data),
        .cmd_dest_x_i (cmd_dx),    .cmd_dest_y_i (cmd_dy),
        .pkt_v_o      (pkt_v),     .pkt_ready_i  (pkt_ready),
        .pkt_op_o     (pkt_op),    .pkt_addr_o   (pkt_addr),
        .pkt_data_o   (pkt_data),  .pkt_dest_x_o (pkt_dx),
        .pkt_dest_y_o (pkt_dy),    .pkt_src_x_o  (pkt_sx),
        .pkt_src_y_o  (pkt_sy),    .resp_v_i     (resp_v),
        .resp_data_i  (resp_data), .rdata_v_o    (rdata_v),
        .rdata_o      (rdata),     .busy_o       (busy),
        .finish_o     (finish),    .error_o      (error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int fin_cnt = 0;
    int fin_cyc = 0;
    int acc_cyc = 0;
    int last_rd_cyc = 0;
    int stall_checks = 0;
    int rel_total = 0;
    int man_fired = 0;
    int stray_req = 0;
    int stray_fired = 0;
    bit auto_resp = 1'b1;
    bit toggle_rdy = 1'b0;
    bit stalled = 1'b0;
    pkt_t got;
    pkt_t saved;
    pkt_t exp_pkt[$];
    logic [DW-1:0] exp_rd[$];
    logic [DW-1:0] load_vals[$];
    int pend_due[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: packet scoreboard, stall stability, load data and finish pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            got = {pkt_op, pkt_addr, pkt_data, pkt_dx, pkt_dy, pkt_sx, pkt_sy};
            if (stalled) begin
                stall_checks++;
                check("stall_hold", 64'({pkt_v, got}), 64'({1'b1, saved}));
            end
            stalled = pkt_v && !pkt_ready;
            saved   = got;
            if (pkt_v && pkt_ready) begin
                hs_cnt++;
                pend_due.push_back(cyc + 2);
                if (exp_pkt.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL pkt_unexpected: got 0x%0h expected none", got);
                end else begin
                    check("pkt", 64'(got), 64'(exp_pkt.pop_front()));
                end
            end
            if (rdata_v) begin
                last_rd_cyc = cyc;
                if (exp_rd.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rdata_unexpected: got 0x%0h expected none", rdata);
                end else begin
                    check("rdata", 64'(rdata), 64'(exp_rd.pop_front()));
                end
            end
            if (finish) begin
                fin_cnt++;
                fin_cyc = cyc;
            end
        end
    end

    // Mesh model: drives ready and returns one response per packet.
    always @(posedge clk) begin
        #1;
        resp_v    = 1'b0;
        pkt_ready = toggle_rdy ? ~pkt_ready : 1'b1;
        if (!rst_n) begin
            pend_due.delete();
        end else if (stray_fired < stray_req) begin
            stray_fired++;
            resp_v    = 1'b1;
            resp_data = 32'h0000_5757;
        end else if (pend_due.size() > 0 && pend_due[0] <= cyc &&
                     (auto_resp || man_fired < rel_total)) begin
            void'(pend_due.pop_front());
            if (!auto_resp) man_fired++;
            resp_v    = 1'b1;
            resp_data = 32'hACCA_CC00;
            if (load_vals.size() > 0) resp_data = load_vals.pop_front();
        end
    end

    task automatic expect_pkt(input logic op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [XW-1:0] dx, input logic [YW-1:0] dy);
        pkt_t p;
        p.op = op; p.addr = a; p.data = d; p.dx = dx; p.dy = dy;
        p.sx = my_x; p.sy = my_y;
        exp_pkt.push_back(p);
    endtask

    task automatic expect_burst(input logic op, input logic [AW-1:0] a, input int len,
                                input logic [DW-1:0] d, input logic [XW-1:0] dx,
                                input logic [YW-1:0] dy);
        for (int i = 0; i < len; i++) begin
            expect_pkt(op, a + AW'(i), op ? '0 : d + DW'(i), dx, dy);
        end
    endtask

    task automatic send_cmd(input logic op, input logic [AW-1:0] a, input logic [LW-1:0] len,
                            input logic [DW-1:0] d, input logic [XW-1:0] dx,
                            input logic [YW-1:0] dy);
        int n;
        bit accepted;
        n = 0;
        accepted = 1'b0;
        @(posedge clk);
        #1;
        cmd_v = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = len;
        cmd_data = d; cmd_dx = dx; cmd_dy = dy;
        while (!accepted && n < 50) begin
            @(negedge clk);
            if (cmd_ready) begin
                accepted = 1'b1;
                acc_cyc  = cyc;
            end
            n++;
        end
        check("cmd_accept", 64'(accepted), 64'(1));
        @(posedge clk);
        #1;
        cmd_v = 1'b0;
    endtask

    task automatic wait_finish(input string name, input int exp, input int budget);
        int n;
        n = 0;
        while (fin_cnt < exp && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({name, "_finish"}, 64'(fin_cnt), 64'(exp));
        check({name, "_drained"}, 64'(exp_pkt.size() + exp_rd.size() + pend_due.size()), 64'(0));
        check({name, "_idle"}, 64'({busy, cmd_ready}), 64'(2'b01));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        int n;
        rst_n = 1'b0; my_x = 2'd2; my_y = 2'd1;
        cmd_v = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_data = '0;
        cmd_dx = '0; cmd_dy = '0; pkt_ready = 1'b1; resp_v = 1'b0; resp_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", 64'({cmd_ready, pkt_v, busy, finish, error, rdata_v}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(cmd_ready), 64'(1));

        // 1: store burst wrapping through the top of the address space
        expect_pkt(1'b0, 10'h3FE, 32'h10, 2'd1, 2'd1);
        expect_pkt(1'b0, 10'h3FF, 32'h11, 2'd1, 2'd1);
        expect_pkt(1'b0, 10'h000, 32'h12, 2'd1, 2'd1);
        expect_pkt(1'b0, 10'h001, 32'h13, 2'd1, 2'd1);
        send_cmd(1'b0, 10'h3FE, 8'd4, 32'h10, 2'd1, 2'd1);
        @(negedge clk);
        check("first_pkt_latency", 64'(pkt_v), 64'(1));
        wait_finish("store", 1, 200);

        // 2: credit limit with responses held back
        auto_resp = 1'b0;
        expect_burst(1'b0, 10'h100, 8, 32'h55, 2'd2, 2'd3);
        h0 = hs_cnt;
        send_cmd(1'b0, 10'h100, 8'd8, 32'h55, 2'd2, 2'd3);
        repeat (20) @(negedge clk);
        check("credit_cap", 64'(hs_cnt - h0), 64'(4));
        check("credit_vld_low", 64'(pkt_v), 64'(0));
        rel_total++;
        repeat (6) @(negedge clk);
        check("credit_one_more", 64'(hs_cnt - h0), 64'(5));
        check("credit_vld_low2", 64'(pkt_v), 64'(0));
        auto_resp = 1'b1;
        wait_finish("credit", 2, 300);

        // 3: load burst returns data in order
        load_vals.push_back(32'hA); load_vals.push_back(32'hB); load_vals.push_back(32'hC);
        exp_rd.push_back(32'hA);    exp_rd.push_back(32'hB);    exp_rd.push_back(32'hC);
        expect_burst(1'b1, 10'h020, 3, 32'hFFFF, 2'd3, 2'd0);
        send_cmd(1'b1, 10'h020, 8'd3, 32'hFFFF, 2'd3, 2'd0);
        wait_finish("load", 3, 200);
        check("load_fin_after_data", 64'(fin_cyc > last_rd_cyc), 64'(1));

        // 4: toggling backpressure with data wrap
        toggle_rdy = 1'b1;
        n = stall_checks;
        expect_burst(1'b0, 10'h3FD, 5, 32'hFFFF_FFFE, 2'd0, 2'd2);
        send_cmd(1'b0, 10'h3FD, 8'd5, 32'hFFFF_FFFE, 2'd0, 2'd2);
        wait_finish("bp", 4, 300);
        toggle_rdy = 1'b0;
        check("bp_stalls_seen", 64'(stall_checks > n), 64'(1));

        // 5: zero-length command
        h0 = hs_cnt;
        send_cmd(1'b0, 10'h0AA, 8'd0, 32'h1, 2'd1, 2'd0);
        wait_finish("len0", 5, 50);
        check("len0_latency", 64'(fin_cyc - acc_cyc), 64'(2));
        check("len0_no_pkts", 64'(hs_cnt - h0), 64'(0));

        // 6: stray response, then reset in the middle of a burst
        check("error_clear", 64'(error), 64'(0));
        stray_req++;
        repeat (4) @(negedge clk);
        check("error_set", 64'(error), 64'(1));
        repeat (4) @(negedge clk);
        check("error_sticky", 64'(error), 64'(1));
        auto_resp = 1'b0;
        expect_burst(1'b0, 10'h040, 8, 32'h1000, 2'd1, 2'd2);
        h0 = hs_cnt;
        send_cmd(1'b0, 10'h040, 8'd8, 32'h1000, 2'd1, 2'd2);
        n = 0;
        while (hs_cnt - h0 < 3 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("mid_burst_reached", 64'(hs_cnt - h0), 64'(3));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_ctrl", 64'({cmd_ready, pkt_v, busy, finish, error, rdata_v}), 64'(0));
        check("reset_mid_pkt", 64'({pkt_addr, pkt_data}), 64'(0));
        exp_pkt.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        auto_resp = 1'b1;
        @(negedge clk);
        check("ready_after_reset2", 64'({cmd_ready, error}), 64'(2'b10));
        expect_pkt(1'b0, 10'h3FF, 32'h7, 2'd2, 2'd2);
        expect_pkt(1'b0, 10'h000, 32'h8, 2'd2, 2'd2);
        send_cmd(1'b0, 10'h3FF, 8'd2, 32'h7, 2'd2, 2'd2);
        wait_finish("post_reset", 6, 100);
        check("error_after_reset", 64'(error), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mesh_burst_driver.md
Name: mesh_burst_driver

Overview:
- Synthesizable, parametrised host-side traffic driver for the manycore mesh.
- Accepts burst commands: op, base address, length, seed data, destination tile.
- Expands each command into per-word remote store or load packets on a valid/ready link.
- Tracks outstanding requests with a credit counter and returns load data to the host.
- Replaces free-running stimulus with a deterministic, self-finishing driver: it pulses finish when every response has returned.

Parameters:
- x_cord_width_p, 2, width of tile X coordinate
- y_cord_width_p, 2, width of tile Y coordinate
- data_width_p, 32, payload width
- addr_width_p, 10, word-address width at destination
- len_width_p, 8, burst-length field width
- max_out_p, 4, maximum outstanding packets (1..2^len_width_p-1)

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- my_x_i  in  x_cord_width_p  source tile X, copied into packets
- my_y_i  in  y_cord_width_p  source tile Y
- cmd_v_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when cmd_v_i && cmd_ready_o
- cmd_op_i  in  1  0=store, 1=load
- cmd_addr_i  in  addr_width_p  base word address
- cmd_len_i  in  len_width_p  number of words
- cmd_data_i  in  data_width_p  store seed value
- cmd_dest_x_i  in  x_cord_width_p  destination X
- cmd_dest_y_i  in  y_cord_width_p  destination Y
- pkt_v_o  out  1  packet valid
- pkt_ready_i  in  1  network ready
- pkt_op_o  out  1  packet op
- pkt_addr_o  out  addr_width_p  packet address
- pkt_data_o  out  data_width_p  packet data (0 for loads)
- pkt_dest_x_o / pkt_dest_y_o  out  x/y widths  destination
- pkt_src_x_o / pkt_src_y_o  out  x/y widths  source
- resp_v_i  in  1  one response per issued packet (store ack or load data)
- resp_data_i  in  data_width_p  response payload
- rdata_v_o  out  1  load data valid (registered, 1 cycle after resp_v_i)
- rdata_o  out  data_width_p  load data
- busy_o  out  1  state != IDLE
- finish_o  out  1  one-cycle pulse at burst completion
- error_o  out  1  sticky: response received with zero outstanding

Behaviour:
- Reset (async, reset_n_i=0):
  - State to IDLE.
  - All outputs 0, except cmd_ready_o=1 once released.
  - Counters cleared; in-flight burst abandoned; late responses after reset set error_o.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - cmd_ready_o=1.
  - On accept, latch all cmd fields; idx=0.
  - len>0 -> ISSUE; len==0 -> DONE directly, no packets.
- ISSUE:
  - pkt_v_o=1 iff outstanding < max_out_p.
  - pkt_addr_o = (base + idx) mod 2^addr_width_p (wraps silently).
  - pkt_data_o = (seed + idx) mod 2^data_width_p for stores.
  - Packet fields stay stable while pkt_v_o && !pkt_ready_i.
  - On handshake: idx++; if idx == len-1 -> DRAIN.
- DRAIN: pkt_v_o=0; when outstanding==0 (counting the current-cycle decrement) -> DONE.
- DONE: finish_o=1 for exactly one cycle -> IDLE. cmd_ready_o=0 in ISSUE/DRAIN/DONE.
- Outstanding counter:
  - +1 on packet handshake, -1 on resp_v_i; both in the same cycle -> unchanged.
  - Never exceeds max_out_p.
  - resp_v_i at outstanding==0 (no simultaneous handshake) -> counter holds at 0, error_o set until reset.
- rdata_v_o=1 the cycle after resp_v_i only if the latched op is load; rdata_o=resp_data_i registered. Store acks produce no rdata_v_o.
- Latency: first packet valid the cycle after command accept. Min burst duration = len + response latency + 2 cycles.

Decomposition:
- Package mesh_driver_pkg:
  - op encoding constants (STORE=0, LOAD=1).
  - FSM state enum.
  - packed packet struct {op, addr, data, dest_x, dest_y, src_x, src_y} parameterised via widths.
- Sub-module mesh_credit_counter: up/down saturating counter with at-limit and zero flags plus an underflow flag; the driver's error_o latches that flag.

Test Plan:
1. Store burst: addr=0x3FE, len=4, seed=0x10, dest (1,1), pkt_ready_i=1, responses 2 cycles after each packet -> addrs 0x3FE, 0x3FF, 0x000, 0x001; data 0x10..0x13; a single finish_o pulse; no rdata_v_o.
2. Credit limit: max_out_p=4, len=8, no responses for 20 cycles -> exactly 4 packets issued, pkt_v_o low. Then 1 response -> 1 more packet.
3. Load burst len=3 with responses 0xA,0xB,0xC -> rdata_v_o three times with the same values in order; finish after the last one.
4. Backpressure: pkt_ready_i toggled 0/1 each cycle -> packet fields stable while stalled; no duplicate or skipped index.
5. len=0 command -> no pkt_v_o; finish_o pulses 2 cycles after accept.
6. Stray resp_v_i in IDLE -> error_o=1 sticky. Reset asserted mid-burst (len=8, 3 issued) -> all outputs 0 immediately; error_o cleared; new command accepted normally.
